// File: rtl/rr_arbiter_4_inputs_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4_inputs_pkg
// Shared definitions for the 4-input round-robin arbiter:
//   - arb_state_e     : FSM state encoding (IDLE=0, GRANTED=1)
//   - DEFAULT_TIMEOUT : default grant cycle budget
//   - idx_to_onehot() : 2-bit index -> 4-bit one-hot grant vector
// ---------------------------------------------------------------------------
package rr_arbiter_4_inputs_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 15;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_inputs_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select_4
// Combinational rotating priority encoder. Searches REQ starting at index
// PTR, then PTR+1, PTR+2, PTR+3 (mod 4) and reports the first set bit.
// Ports:
//   REQ   [3:0] in  : request vector
//   PTR   [1:0] in  : index with highest priority this round
//   VALID       out : at least one request is set
//   SEL   [1:0] out : winning requester index (0 when VALID=0)
// ---------------------------------------------------------------------------
module rr_priority_select_4 (
    input  logic [3:0] REQ,
    input  logic [1:0] PTR,
    output logic       VALID,
    output logic [1:0] SEL
);

    // rot[k] is the request that sits k positions after PTR, so a fixed
    // priority search over rot gives the rotating search over REQ.
    logic [3:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] src_idx;
            assign src_idx = PTR + 2'(gi);
            assign rot[gi] = REQ[src_idx];
        end
    endgenerate

    logic [1:0] offset;

    always_comb begin
        offset = 2'd0;
        if (rot[0])      offset = 2'd0;
        else if (rot[1]) offset = 2'd1;
        else if (rot[2]) offset = 2'd2;
        else if (rot[3]) offset = 2'd3;
    end

    assign VALID = |REQ;
    assign SEL   = VALID ? (PTR + offset) : 2'd0;

endmodule

// File: rtl/rr_arbiter_4_inputs.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4_inputs
// Round-robin arbiter sharing one downstream resource among 4 requesters.
// A grant is held until DONE, the owner drops its request, or the grant has
// lasted TIMEOUT cycles. At least one idle cycle separates grants.
// Ports:
//   CLK               in  : clock, rising edge
//   RST               in  : synchronous active-high reset
//   REQ   [3:0]       in  : request vector
//   DONE              in  : owner finished (only looked at while GRANTED)
//   GNT   [3:0]       out : registered one-hot grant (zero when idle)
//   GNT_ID[1:0]       out : registered index of current / last grantee
//   BUSY              out : 1 while GRANTED
//   TIMEOUT_FLAG      out : one-cycle pulse when a grant is revoked by timeout
// ---------------------------------------------------------------------------
module rr_arbiter_4_inputs
    import rr_arbiter_4_inputs_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic [1:0]       GNT_ID,
    output logic             BUSY,
    output logic             TIMEOUT_FLAG
);

    arb_state_e  state_q;
    logic [1:0]  ptr_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]  gnt_q;
    logic [1:0]  gnt_id_q;
    logic        busy_q;
    logic        tflag_q;

    // Rotating search for the next winner
    logic       sel_valid;
    logic [1:0] sel_idx;

    rr_priority_select_4 u_sel (
        .REQ   (REQ),
        .PTR   (ptr_q),
        .VALID (sel_valid),
        .SEL   (sel_idx)
    );

    // Release conditions while GRANTED. DONE dominates, so a timeout that
    // coincides with DONE or a request drop never raises the flag.
    logic owner_req;
    logic budget_spent;
    logic release_d;
    logic timeout_d;

    assign owner_req    = REQ[gnt_id_q];
    assign budget_spent = (cnt_q == CW'(TIMEOUT - 1));
    assign release_d    = DONE || !owner_req || budget_spent;
    assign timeout_d    = !DONE && owner_req && budget_spent;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
            tflag_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tflag_q <= 1'b0;
                    if (sel_valid) begin
                        state_q  <= ST_GRANTED;
                        gnt_q    <= idx_to_onehot(sel_idx);
                        gnt_id_q <= sel_idx;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                ST_GRANTED: begin
                    if (release_d) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        tflag_q <= timeout_d;
                        // 2-bit add wraps 3 -> 0
                        ptr_q   <= gnt_id_q + 2'd1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        tflag_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                    tflag_q <= 1'b0;
                end
            endcase
        end
    end

    assign GNT          = gnt_q;
    assign GNT_ID       = gnt_id_q;
    assign BUSY         = busy_q;
    assign TIMEOUT_FLAG = tflag_q;

    a_gnt_onehot0 : assert property (@(posedge CLK) $onehot0(GNT));
    a_busy_match  : assert property (@(posedge CLK) BUSY == (|GNT));

endmodule

// File: tb/tb_rr_arbiter_4_inputs.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_4_inputs
// Directed, table-driven bench for rr_arbiter_4_inputs. Each vector gives the
// inputs driven before a rising edge and the outputs expected just after it.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_4_inputs;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       tflag;

    int n_vec;
    int n_bad;

    rr_arbiter_4_inputs #(
        .N_REQ   (4),
        .TIMEOUT (15),
        .CW      (4)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .REQ          (req),
        .DONE         (done),
        .GNT          (gnt),
        .GNT_ID       (gnt_id),
        .BUSY         (busy),
        .TIMEOUT_FLAG (tflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       tf;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d,
                                input logic [3:0] g, input logic [1:0] i,
                                input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.done = d;
        v.gnt = g; v.id = i; v.busy = b; v.tf = t;
        return v;
    endfunction

    // Drive one set of inputs, clock once, compare all outputs.
    task automatic step(input string name, input logic r, input logic [3:0] q,
                        input logic d, input logic [3:0] eg, input logic [1:0] ei,
                        input logic eb, input logic et);
        @(negedge clk);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        #1;
        n_vec++;
        if (gnt !== eg || gnt_id !== ei || busy !== eb || tflag !== et) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b tf=%b, want gnt=%b id=%0d busy=%b tf=%b",
                     name, gnt, gnt_id, busy, tflag, eg, ei, eb, et);
        end else begin
            $display("ok   %s: req=%b done=%b -> gnt=%b id=%0d busy=%b tf=%b",
                     name, q, d, gnt, gnt_id, busy, tflag);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;

        //            rst req     done  gnt     id  busy tf
        // reset held two cycles with all requests up
        tbl[0]  = mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
        // rotation 0,1,2,3,0 with DONE two cycles after each grant
        tbl[2]  = mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
        tbl[3]  = mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
        tbl[4]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        tbl[5]  = mk(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        tbl[6]  = mk(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        tbl[7]  = mk(0, 4'b1111, 1, 4'b0000, 1, 0, 0);
        tbl[8]  = mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
        tbl[9]  = mk(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
        tbl[10] = mk(0, 4'b1111, 1, 4'b0000, 2, 0, 0);
        tbl[11] = mk(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        tbl[12] = mk(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        tbl[13] = mk(0, 4'b1111, 1, 4'b0000, 3, 0, 0);
        tbl[14] = mk(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
        tbl[15] = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        // serve requester 2, leaving the pointer at 3; then skip and wrap
        tbl[16] = mk(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
        tbl[17] = mk(0, 4'b0101, 1, 4'b0000, 2, 0, 0);
        tbl[18] = mk(0, 4'b0101, 0, 4'b0001, 0, 1, 0);
        tbl[19] = mk(0, 4'b0101, 1, 4'b0000, 0, 0, 0);
        tbl[20] = mk(0, 4'b0101, 0, 4'b0100, 2, 1, 0);
        // non-owner changes are ignored, then owner drops its request
        tbl[21] = mk(0, 4'b0111, 0, 4'b0100, 2, 1, 0);
        tbl[22] = mk(0, 4'b0011, 0, 4'b0000, 2, 0, 0);
        tbl[23] = mk(0, 4'b0011, 0, 4'b0001, 0, 1, 0);
        // DONE together with a request drop, then stay idle
        tbl[24] = mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        tbl[25] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0);

        for (int i = 0; i < 26; i++) begin
            step($sformatf("tbl[%0d]", i), tbl[i].rst, tbl[i].req, tbl[i].done,
                 tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].tf);
        end

        // Timeout: pointer is 1, requester 1 holds its request, no DONE.
        // The grant lasts 15 cycles, then drops with a one-cycle flag.
        step("to_grant", 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        for (int i = 1; i <= 14; i++) begin
            step($sformatf("to_hold%0d", i), 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        end
        step("to_release", 0, 4'b0010, 0, 4'b0000, 1, 0, 1);
        step("to_regrant", 0, 4'b0010, 0, 4'b0010, 1, 1, 0);

        // DONE on the 15th grant cycle: released without the flag.
        for (int i = 1; i <= 14; i++) begin
            step($sformatf("dt_hold%0d", i), 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        end
        step("dt_release", 0, 4'b0010, 1, 4'b0000, 1, 0, 0);
        step("dt_idle", 0, 4'b0000, 0, 4'b0000, 1, 0, 0);

        // Reset mid-grant with CNT=7; pointer returns to 0.
        step("rm_grant", 0, 4'b0100, 0, 4'b0100, 2, 1, 0);
        for (int i = 1; i <= 7; i++) begin
            step($sformatf("rm_hold%0d", i), 0, 4'b0100, 0, 4'b0100, 2, 1, 0);
        end
        step("rm_reset", 1, 4'b0100, 0, 4'b0000, 0, 0, 0);
        step("rm_after", 0, 4'b1100, 0, 4'b0100, 2, 1, 0);
        // after releasing 2 the pointer is 3, so requester 3 is next
        step("rm_done", 0, 4'b1100, 1, 4'b0000, 2, 0, 0);
        step("rm_next", 0, 4'b1100, 0, 4'b1000, 3, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4_inputs.md
Name: rr_arbiter_4_inputs

Overview:
- Round-robin arbiter that shares one downstream resource between four requesters.
- The resource is a shared datapath built from the team's gate primitives, e.g. a display/segment driver or an output bus.
- At most one requester is granted at a time.
- A grant is held until the owner signals DONE, drops its request, or exceeds a cycle budget (timeout).
- Sits between the requesting control units and the shared combinational datapath. GNT_ID drives the datapath's input mux select.

Parameters:
- N_REQ, 4, number of requesters. Fixed at 4; the parameter exists for documentation and assertions only.
- TIMEOUT, 15, maximum cycles a grant may be held. Legal range 1..15.
- CW, 4, hold-counter width. Must satisfy 2^CW > TIMEOUT.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  request vector; REQ[i]=1 means requester i wants the resource.
- DONE  input  1  owner finished; sampled only in GRANTED state.
- GNT  output  4  one-hot grant, registered; all-zero when nothing is granted.
- GNT_ID  output  2  binary index of current/last grantee, registered.
- BUSY  output  1  1 while in GRANTED state.
- TIMEOUT_FLAG  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (RST=1 at a rising edge):
  - GNT=0000, GNT_ID=00, BUSY=0, TIMEOUT_FLAG=0.
  - Rotation pointer PTR=00, hold counter CNT=0, state=IDLE.
  - Reset overrides all other inputs, including mid-grant: the grant is dropped at that edge.
- States: IDLE, GRANTED. 1-bit encoding: IDLE=0, GRANTED=1.
- IDLE:
  - GNT=0000.
  - If REQ≠0000, select the first i with REQ[i]=1, searching PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - At the next edge: GNT[i]=1, GNT_ID=i, BUSY=1, CNT=0, state=GRANTED.
  - If REQ=0000, remain in IDLE with no output change.
- Latency: a request sampled in IDLE produces a grant exactly 1 cycle later.
- GRANTED, evaluated every edge with g=GNT_ID:
  - Release by DONE: DONE=1 releases. TIMEOUT_FLAG=0.
  - Release by request drop: REQ[g]=0 releases. TIMEOUT_FLAG=0.
  - Release by timeout: DONE=0, REQ[g]=1 and CNT==TIMEOUT-1 releases with TIMEOUT_FLAG=1 for one cycle.
  - Otherwise CNT=CNT+1 and the grant is held.
  - On any release: GNT=0000, BUSY=0, state=IDLE, PTR=g+1 mod 4 (3 wraps to 0). GNT_ID keeps g.
- Grant duration: a grant lasts at most TIMEOUT cycles.
- Release gap: there is always at least one IDLE cycle (GNT=0000) between consecutive grants, including back-to-back requests by the same or different requesters.
- Priority when events coincide: DONE beats request drop beats timeout. TIMEOUT_FLAG is never set when DONE=1 in the same cycle.
- Non-owner requests: changes to REQ[j], j≠g, during GRANTED are ignored until IDLE.
- TIMEOUT_FLAG is cleared at every edge where it is not newly set.
- Invariants:
  - GNT is always one-hot or zero.
  - BUSY == |GNT.
  - CNT never exceeds TIMEOUT-1.

Decomposition:
- Shared constants in one include file, arbiter_defs:
  - state encodings ST_IDLE / ST_GRANTED.
  - default TIMEOUT value.
- One sub-module, rr_priority_select_4: combinational rotating priority encoder.
  - Inputs: REQ[3:0], PTR[1:0].
  - Outputs: VALID, SEL[1:0].
  - May be built from and_gate_*/or_gate_* primitives.
- The FSM, counter and pointer live in the top module.

Test Plan:
- Reset: RST=1 for 2 cycles with REQ=1111 → GNT=0000, BUSY=0, GNT_ID=00, TIMEOUT_FLAG=0 throughout. First grant after reset goes to requester 0 (GNT=0001).
- Rotation: REQ=1111 held; owner pulses DONE 2 cycles after each grant → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one GNT=0000 cycle between grants.
- Skip and wrap: PTR=3 (after requester 2 served), REQ=0101 → GNT=0001 (requester 0). Next grant with REQ=0101 → GNT=0100.
- Timeout: TIMEOUT=15, REQ=0010 held, DONE=0 → GNT=0010 for exactly 15 cycles. TIMEOUT_FLAG=1 for one cycle coincident with GNT=0000. Regrant to 0010 one cycle later.
- Simultaneous DONE and timeout: DONE=1 on the 15th grant cycle → release with TIMEOUT_FLAG=0. Request drop: REQ[g] falls mid-grant → GNT=0000 at the next edge.
- Reset mid-grant: GNT=0100 with CNT=7, RST=1 for one cycle → GNT=0000, PTR=0. With REQ=1100, the next grant is GNT=0100 (search starts at 0).
